stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/opcode_type_pkg.sv | 23 ++
 rtl/seq_pkg.sv | 39 +++
 rtl/instret_counter.sv | 27 ++
 rtl/stage_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_stage_sequencer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/opcode_type_pkg.sv
// Opcode class definitions shared by the decoder and the stage sequencer.
//
// opcode_t is a one-hot vector with one bit per instruction class. A legal
// decode sets exactly one bit. Bit positions are given by the Op* indices.
package opcode_type_pkg;

  localparam int unsigned NumOpClasses = 11;

  typedef logic [NumOpClasses-1:0] opcode_t;

  localparam int unsigned OpLui      = 0;
  localparam int unsigned OpAuipc    = 1;
  localparam int unsigned OpJal      = 2;
  localparam int unsigned OpJalr     = 3;
  localparam int unsigned OpBranch   = 4;
  localparam int unsigned OpLoad     = 5;
  localparam int unsigned OpStore    = 6;
  localparam int unsigned OpImmArith = 7;
  localparam int unsigned OpRegArith = 8;
  localparam int unsigned OpFence    = 9;
  localparam int unsigned OpSystem   = 10;

endpackage

// File: rtl/seq_pkg.sv
// Shared types and encodings for the stage sequencer.
//
// Contents: FSM state enum, pc_sel / wb_sel encodings and a helper that
// flags an illegal opcode class (no bits set or more than one bit set).
// Config macro: SEQ_ILLEGAL_TRAP_EN adds the StTrap state.
package seq_pkg;

  import opcode_type_pkg::*;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb
`ifdef SEQ_ILLEGAL_TRAP_EN
    ,
    StTrap
`endif
  } seq_state_e;

  // Next-PC source
  localparam logic [1:0] PcSelPlus4  = 2'b00;
  localparam logic [1:0] PcSelTarget = 2'b01;
  localparam logic [1:0] PcSelTrap   = 2'b10;

  // Writeback source
  localparam logic [1:0] WbSelAlu = 2'b00;
  localparam logic [1:0] WbSelMem = 2'b01;
  localparam logic [1:0] WbSelPc4 = 2'b10;

  // Illegal when the vector is not exactly one-hot. x & (x-1) clears the
  // lowest set bit, so a non-zero result means a second bit was set.
  function automatic logic class_illegal(input opcode_t op);
    return (op == '0) || ((op & (op - 1'b1)) != '0);
  endfunction

endpackage

// File: rtl/instret_counter.sv
// Retired-instruction counter.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset, clears the count
//   inc   - add one to the count on the next edge
//   count - current count, wraps from all-ones to zero
module instret_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer.
//
// Steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB,
// raising the memory handshakes and the PC / register-file strobes for the
// datapath. Outputs are decoded from the state register and the class
// registered in DECODE; ir_we additionally follows imem_ack during FETCH.
//
// Config macro: SEQ_ILLEGAL_TRAP_EN
//   defined   - illegal classes take a one-cycle TRAP state (trap=1,
//               pc_sel=trap vector, no retire)
//   undefined - illegal classes retire as a NOP through WB; trap tied to 0
//
// Ports:
//   clk, rst      - clock (rising edge), asynchronous active-low reset
//   opcode_type   - one-hot class from the decoder, sampled in DECODE
//   imem_req/ack  - instruction fetch handshake; ir_we loads the IR
//   branch_taken  - comparator result, sampled in EXEC for branches
//   dmem_req/we/ack - data memory handshake
//   pc_we, pc_sel - PC update strobe and source select
//   rf_we, wb_sel - register file write and writeback source select
//   trap, retire  - illegal-instruction and instruction-complete pulses
//   instret       - retired-instruction count
module stage_sequencer
  import opcode_type_pkg::*;
  import seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  opcode_t     opcode_type,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_we,
  input  logic        branch_taken,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        trap,
  output logic        retire,
  output logic [31:0] instret
);

  seq_state_e state_q, state_d;
  opcode_t    class_q;
  logic       taken_q;
  logic       cls_illegal;
  logic       cls_mem;

  assign cls_illegal = class_illegal(class_q);
  assign cls_mem     = class_q[OpLoad] | class_q[OpStore];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Class and branch outcome are captured once per instruction and held
  // until the next instruction overwrites them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      class_q <= '0;
      taken_q <= 1'b0;
    end else begin
      if (state_q == StDecode) begin
        class_q <= opcode_type;
      end
      if (state_q == StExec && class_q[OpBranch]) begin
        taken_q <= branch_taken;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   state_d = StFetch;
      StFetch:  if (imem_ack) state_d = StDecode;
      StDecode: state_d = StExec;
      StExec: begin
        if (cls_illegal) begin
`ifdef SEQ_ILLEGAL_TRAP_EN
          state_d = StTrap;
`else
          state_d = StWb;
`endif
        end else if (cls_mem) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem:    if (dmem_ack) state_d = StWb;
      StWb:     state_d = StFetch;
`ifdef SEQ_ILLEGAL_TRAP_EN
      StTrap:   state_d = StFetch;
`endif
      default:  state_d = StIdle;
    endcase
  end

  // Output decode
  logic trap_d;

  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PcSelPlus4;
    rf_we    = 1'b0;
    wb_sel   = WbSelAlu;
    trap_d   = 1'b0;
    retire   = 1'b0;
    case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = class_q[OpStore];
      end
      StWb: begin
        pc_we  = 1'b1;
        retire = 1'b1;
        // An illegal class only reaches WB when trapping is disabled; it
        // then retires as a NOP with all per-class outputs left at 0.
        if (!cls_illegal) begin
          unique case (1'b1)
            class_q[OpLui], class_q[OpAuipc],
            class_q[OpImmArith], class_q[OpRegArith]: begin
              rf_we  = 1'b1;
              wb_sel = WbSelAlu;
            end
            class_q[OpJal], class_q[OpJalr]: begin
              rf_we  = 1'b1;
              wb_sel = WbSelPc4;
              pc_sel = PcSelTarget;
            end
            class_q[OpBranch]: begin
              pc_sel = taken_q ? PcSelTarget : PcSelPlus4;
            end
            class_q[OpLoad]: begin
              rf_we  = 1'b1;
              wb_sel = WbSelMem;
            end
            class_q[OpStore], class_q[OpFence], class_q[OpSystem]: begin
              rf_we = 1'b0;
            end
            default: ;
          endcase
        end
      end
`ifdef SEQ_ILLEGAL_TRAP_EN
      StTrap: begin
        trap_d = 1'b1;
        pc_we  = 1'b1;
        pc_sel = PcSelTrap;
      end
`endif
      default: ;
    endcase
  end

`ifdef SEQ_ILLEGAL_TRAP_EN
  assign trap = trap_d;
`else
  assign trap = 1'b0;
  logic unused_trap;
  assign unused_trap = trap_d;
`endif

  instret_counter u_instret (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire),
    .count (instret)
  );

endmodule

// File: tb/tb_stage_sequencer.sv
module tb_stage_sequencer;
  import opcode_type_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  opcode_t     opcode_type;
  logic        imem_req, imem_ack, ir_we, branch_taken;
  logic        dmem_req, dmem_we, dmem_ack;
  logic        pc_we, rf_we, trap, retire;
  logic [1:0]  pc_sel, wb_sel;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_ret;

  stage_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .opcode_type  (opcode_type),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .ir_we        (ir_we),
    .branch_taken (branch_taken),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ack     (dmem_ack),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .trap         (trap),
    .retire       (retire),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic opcode_t cls(input int unsigned idx);
    opcode_t v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Called in FETCH; returns in EXEC with the class registered.
  task automatic issue(input opcode_t op);
    imem_ack    = 1'b1;
    opcode_type = op;
    tick();
    imem_ack = 1'b0;
    tick();
  endtask

  initial begin
    rst          = 1'b0;
    opcode_type  = '0;
    imem_ack     = 1'b0;
    branch_taken = 1'b0;
    dmem_ack     = 1'b0;
    exp_ret      = 32'd0;

    // Reset state
    tick();
    tick();
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc_we", {31'd0, pc_we}, 32'd0);
    chk("rst_retire", {31'd0, retire}, 32'd0);
    chk("rst_sel", {28'd0, pc_sel, wb_sel}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    rst = 1'b1;
    #1;
    chk("idle_imem_req", {31'd0, imem_req}, 32'd0);

    // ADD: FETCH, DECODE, EXEC, WB on consecutive cycles
    tick();
    chk("fetch_imem_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_ir_we_noack", {31'd0, ir_we}, 32'd0);
    imem_ack    = 1'b1;
    opcode_type = cls(OpRegArith);
    #1;
    chk("fetch_ir_we_ack", {31'd0, ir_we}, 32'd1);
    tick();
    imem_ack = 1'b0;
    chk("decode_imem_req", {31'd0, imem_req}, 32'd0);
    tick();
    tick();
    chk("add_wb_ctl", {28'd0, rf_we, pc_we, retire, dmem_req}, 32'b1110);
    chk("add_wb_sel", {28'd0, pc_sel, wb_sel}, 32'd0);
    tick();
    exp_ret = 32'd1;
    chk("add_instret", instret, exp_ret);
    chk("add_back_fetch", {31'd0, imem_req}, 32'd1);

    // LOAD with dmem_ack on the 4th MEM cycle
    issue(cls(OpLoad));
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem_ack = 1'b1;
      chk($sformatf("load_mem_req%0d", i), {30'd0, dmem_req, dmem_we}, 32'b10);
      tick();
    end
    dmem_ack = 1'b0;
    chk("load_wb", {28'd0, rf_we, retire, dmem_req, trap}, 32'b1100);
    chk("load_wb_sel", {28'd0, pc_sel, wb_sel}, {28'd0, 2'b00, 2'b01});
    tick();
    exp_ret = 32'd2;
    chk("load_instret", instret, exp_ret);

    // BRANCH taken then not taken; taken is only sampled in EXEC
    issue(cls(OpBranch));
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    #1;
    chk("br_taken_wb", {28'd0, pc_sel, 1'b0, rf_we, pc_we}, {28'd0, 2'b01, 1'b0, 1'b0, 1'b1});
    tick();
    issue(cls(OpBranch));
    tick();
    branch_taken = 1'b1;
    #1;
    chk("br_ntaken_wb", {28'd0, pc_sel, 1'b0, rf_we, retire}, {28'd0, 2'b00, 1'b0, 1'b0, 1'b1});
    branch_taken = 1'b0;
    tick();
    exp_ret = 32'd4;
    chk("br_instret", instret, exp_ret);

    // JAL
    issue(cls(OpJal));
    tick();
    chk("jal_wb", {27'd0, rf_we, pc_sel, wb_sel}, {27'd0, 1'b1, 2'b01, 2'b10});
    tick();
    exp_ret = 32'd5;

    // Illegal: zero bits, then two bits set (must not enter MEM)
    for (int k = 0; k < 2; k++) begin
      if (k == 0) issue('0);
      else issue(cls(OpLoad) | cls(OpStore));
      tick();
      chk($sformatf("ill%0d_no_mem", k), {31'd0, dmem_req}, 32'd0);
`ifdef SEQ_ILLEGAL_TRAP_EN
      chk($sformatf("ill%0d_trap", k), {26'd0, trap, pc_we, retire, rf_we, pc_sel},
          {26'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10});
`else
      chk($sformatf("ill%0d_nop", k), {26'd0, trap, pc_we, retire, rf_we, pc_sel},
          {26'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00});
      exp_ret = exp_ret + 32'd1;
`endif
      tick();
      chk($sformatf("ill%0d_instret", k), instret, exp_ret);
      chk($sformatf("ill%0d_fetch", k), {31'd0, imem_req}, 32'd1);
    end

    // Reset during MEM of a STORE, then a late ack
    issue(cls(OpStore));
    tick();
    chk("st_mem", {29'd0, dmem_req, dmem_we, rf_we}, 32'b110);
    #2;
    rst = 1'b0;
    #1;
    chk("st_rst_drop", {30'd0, dmem_req, dmem_we}, 32'd0);
    chk("st_rst_instret", instret, 32'd0);
    dmem_ack = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    chk("st_rel_idle", {30'd0, imem_req, dmem_req}, 32'd0);
    tick();
    dmem_ack = 1'b0;
    chk("st_rel_fetch", {30'd0, imem_req, dmem_req}, 32'b10);
    chk("st_rel_instret", instret, 32'd0);

    // Counter wrap: preload all-ones while idling in FETCH
    force dut.u_instret.count_q = 32'hFFFF_FFFF;
    tick();
    release dut.u_instret.count_q;
    tick();
    chk("wrap_preload", instret, 32'hFFFF_FFFF);
    issue(cls(OpLui));
    tick();
    chk("wrap_wb_retire", {31'd0, retire}, 32'd1);
    tick();
    chk("wrap_instret", instret, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
